phy_rx: RTL and testbench
=========================

PHY_RX -- requirements
Module: phy_rx

Interface
REQ-001 The module SHALL have these ports (name, direction, width, meaning), clock and reset first:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- data_in  in  1  serial line bit, bytes sent MSB first
- out0  out  8  lane-0 byte of last completed group
- out1  out  8  lane-1 byte of last completed group
- out2  out  8  lane-2 byte of last completed group
- out3  out  8  lane-3 byte of last completed group
- valid_out  out  1  one-cycle pulse: out0..out3 hold a new group
- active  out  1  high while the receiver is in state ACTIVE
- err  out  1  one-cycle pulse: partial group discarded

REQ-002 The block SHALL be synchronous to clk only, with synchronous active-high reset.

REQ-003 The block SHALL have these parameters (name, default, meaning):
- COM, 8'hBC, alignment/lane-restart symbol
- IDL, 8'h7C, idle filler symbol
- ALIGN_N, 4, consecutive COMs needed to lock

Function
REQ-004 The block SHALL shift data_in into an 8-bit shift register every cycle; candidate byte = {sr[6:0], data_in}.
REQ-005 The block SHALL implement FSM states SEARCH, ALIGN and ACTIVE.
REQ-006 SEARCH: the block SHALL compare the candidate byte every cycle (bit-granular).
- On candidate == COM: go to ALIGN, clear bit_cnt to 0, set com_cnt = 1.
REQ-007 Outside SEARCH, a byte SHALL complete when bit_cnt == 7, after which bit_cnt wraps to 0.
- The completed byte is the candidate byte in that cycle.
REQ-008 ALIGN, completed byte == COM: the block SHALL increment com_cnt.
- When com_cnt reaches ALIGN_N: go to ACTIVE, clear lane_idx to 0.
REQ-009 ALIGN, completed byte != COM: the block SHALL return to SEARCH and clear com_cnt.
REQ-010 ACTIVE, COM byte: the block SHALL set lane_idx to 0 and SHALL not store the byte.
- If lane_idx != 0 at that moment: pulse err the next cycle and discard the stored partial bytes.
REQ-011 ACTIVE, IDL byte: the block SHALL discard it and leave lane_idx unchanged.
REQ-012 ACTIVE, any other byte: the block SHALL store it in lane[lane_idx] and increment lane_idx mod 4.
REQ-013 When the lane-3 byte is stored, the block SHALL do the following on the next cycle:
- load out0..out3 from lanes 0..3;
- assert valid_out for exactly one cycle.
REQ-014 Outputs out0..out3 SHALL hold their values until the next group completes.
REQ-015 ACTIVE SHALL persist until reset; the block SHALL not leave ACTIVE on data content.
REQ-016 The active output SHALL be registered and SHALL be high starting the cycle after the FSM enters ACTIVE.
REQ-017 The COM that completes alignment SHALL not produce err and SHALL not be stored.
REQ-018 valid_out and err SHALL never be asserted outside ACTIVE.

Reset
REQ-019 When reset is high at a clk edge, the block SHALL enter SEARCH and clear all of the following to 0:
- sr, bit_cnt, com_cnt, lane_idx, lane registers;
- out0..out3, valid_out, active, err.
REQ-020 Reset SHALL take priority over all other events, including mid-byte and mid-group.
- Any partial byte or group SHALL be discarded without an err pulse.
REQ-021 The first data_in bit sampled after reset deasserts SHALL be the first bit shifted into sr.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Lock: after reset, send 4x 8'hBC. Expect SEARCH->ALIGN on the 8th bit, active high 1 cycle after the 32nd bit, and no valid_out or err.
- Data group: after lock, send 8'h11, 8'h22, 8'h33, 8'h44. Expect a valid_out pulse 1 cycle after the last bit with out0=11, out1=22, out2=33, out3=44, held afterwards.
- Idle and misalignment: after lock, send 11, 7C, 22, 33, 7C, 44. Expect the same result as the data-group case. Prepend 3 random bits before the 4 COMs; lock must still occur, bit-aligned.
- Partial group: after lock, send 11, 22, BC, then 55, 66, 77, 88. Expect one err pulse after the BC, no valid_out for 11/22, then out0..out3 = 55, 66, 77, 88.
- Alignment failure: send BC, BC, 8'h00, BC. Expect a return to SEARCH on the 00 byte and active staying low; a further 4x BC then locks.
- Reset mid-group: after lock, send 11, 22, assert reset for 1 cycle, then relock and send 99, AA, BB, CC. Expect all outputs 0 after reset, no err, then out0..out3 = 99, AA, BB, CC.

Source files
------------

// File: rtl/phy_rx.sv
// Serial-to-4-lane byte receiver: bit-granular COM hunt, ALIGN_N-COM lock, then lane striping with IDL skip.
// Outputs are registered one cycle after the completing bit; no backpressure (the serial line cannot stall).
module phy_rx #(
  parameter logic [7:0] COM     = 8'hBC,
  parameter logic [7:0] IDL     = 8'h7C,
  parameter int         ALIGN_N = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] out0,
  output logic [7:0] out1,
  output logic [7:0] out2,
  output logic [7:0] out3,
  output logic       valid_out,
  output logic       active,
  output logic       err
);

  localparam int CW = $clog2(ALIGN_N + 1);

  typedef enum logic [1:0] {SEARCH, ALIGN, ACTIVE} state_t;

  state_t          state_q, state_d;
  logic [7:0]      sr_q, sr_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]   com_cnt_q, com_cnt_d;
  logic [1:0]      lane_idx_q, lane_idx_d;
  logic [7:0]      lane0_q, lane0_d, lane1_q, lane1_d, lane2_q, lane2_d;
  logic [7:0]      out0_q, out0_d, out1_q, out1_d, out2_q, out2_d, out3_q, out3_d;
  logic            valid_q, valid_d, err_q, err_d, active_q, active_d;
  logic [7:0]      cand;
  logic            byte_done;

  assign cand      = {sr_q[6:0], data_in};
  assign byte_done = (bit_cnt_q == 3'd7);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= SEARCH;
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      com_cnt_q  <= '0;
      lane_idx_q <= '0;
      lane0_q    <= '0;
      lane1_q    <= '0;
      lane2_q    <= '0;
      out0_q     <= '0;
      out1_q     <= '0;
      out2_q     <= '0;
      out3_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      com_cnt_q  <= com_cnt_d;
      lane_idx_q <= lane_idx_d;
      lane0_q    <= lane0_d;
      lane1_q    <= lane1_d;
      lane2_q    <= lane2_d;
      out0_q     <= out0_d;
      out1_q     <= out1_d;
      out2_q     <= out2_d;
      out3_q     <= out3_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      active_q   <= active_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sr_d       = cand;
    bit_cnt_d  = bit_cnt_q + 3'd1;
    com_cnt_d  = com_cnt_q;
    lane_idx_d = lane_idx_q;
    lane0_d    = lane0_q;
    lane1_d    = lane1_q;
    lane2_d    = lane2_q;
    out0_d     = out0_q;
    out1_d     = out1_q;
    out2_d     = out2_q;
    out3_d     = out3_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      SEARCH: begin
        bit_cnt_d = 3'd0;
        if (cand == COM) begin
          com_cnt_d  = CW'(1);
          lane_idx_d = 2'd0;
          state_d    = (ALIGN_N <= 1) ? ACTIVE : ALIGN;
        end
      end

      ALIGN: begin
        if (byte_done) begin
          if (cand == COM) begin
            com_cnt_d = com_cnt_q + CW'(1);
            if (com_cnt_d == CW'(ALIGN_N)) begin
              state_d    = ACTIVE;
              lane_idx_d = 2'd0;
            end
          end else begin
            state_d   = SEARCH;
            com_cnt_d = '0;
          end
        end
      end

      ACTIVE: begin
        if (byte_done) begin
          if (cand == COM) begin
            // COM restarts striping; a half-filled group is dropped and flagged
            lane_idx_d = 2'd0;
            err_d      = (lane_idx_q != 2'd0);
            lane0_d    = '0;
            lane1_d    = '0;
            lane2_d    = '0;
          end else if (cand != IDL) begin
            lane_idx_d = lane_idx_q + 2'd1;
            case (lane_idx_q)
              2'd0: lane0_d = cand;
              2'd1: lane1_d = cand;
              2'd2: lane2_d = cand;
              default: begin
                out0_d  = lane0_q;
                out1_d  = lane1_q;
                out2_d  = lane2_q;
                out3_d  = cand;
                valid_d = 1'b1;
              end
            endcase
          end
        end
      end

      default: state_d = SEARCH;
    endcase

    active_d = (state_d == ACTIVE);
  end

  assign out0      = out0_q;
  assign out1      = out1_q;
  assign out2      = out2_q;
  assign out3      = out3_q;
  assign valid_out = valid_q;
  assign err       = err_q;
  assign active    = active_q;

endmodule

// File: tb/tb_phy_rx.sv
// Directed bench for phy_rx: a queue-based reference model checked every cycle, plus literal spot checks.
module tb_phy_rx;

  logic       clk;
  logic       reset;
  logic       data_in;
  logic [7:0] out0, out1, out2, out3;
  logic       valid_out, active, err;

  int n_chk = 0;
  int n_err = 0;
  int vcnt  = 0;
  int ecnt  = 0;

  phy_rx dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .out0      (out0),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .valid_out (valid_out),
    .active    (active),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: tracks line history, bit position since the last framed byte,
  // and the pending group as a queue of bytes.
  int         m_phase;   // 0 hunting, 1 counting COMs, 2 locked
  int         m_pos;
  int         m_coms;
  logic [7:0] m_hist;
  logic [7:0] m_grp[$];
  logic [7:0] e_out[4];
  logic       e_valid, e_err, e_active;

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0; m_pos = 0; m_coms = 0; m_hist = 8'h00;
      m_grp.delete();
      for (int i = 0; i < 4; i++) e_out[i] = 8'h00;
      e_valid = 1'b0; e_err = 1'b0; e_active = 1'b0;
    end else begin
      e_valid = 1'b0;
      e_err   = 1'b0;
      m_hist  = {m_hist[6:0], data_in};
      if (m_phase == 0) begin
        if (m_hist == 8'hBC) begin
          m_phase = 1; m_pos = 0; m_coms = 1;
        end
      end else begin
        m_pos = m_pos + 1;
        if (m_pos == 8) begin
          m_pos = 0;
          if (m_phase == 1) begin
            if (m_hist == 8'hBC) begin
              m_coms = m_coms + 1;
              if (m_coms == 4) begin
                m_phase = 2;
                m_grp.delete();
              end
            end else begin
              m_phase = 0; m_coms = 0;
            end
          end else begin
            if (m_hist == 8'hBC) begin
              if (m_grp.size() != 0) e_err = 1'b1;
              m_grp.delete();
            end else if (m_hist != 8'h7C) begin
              m_grp.push_back(m_hist);
              if (m_grp.size() == 4) begin
                for (int i = 0; i < 4; i++) e_out[i] = m_grp[i];
                e_valid = 1'b1;
                m_grp.delete();
              end
            end
          end
        end
      end
      e_active = (m_phase == 2);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("out0", {24'h0, out0}, {24'h0, e_out[0]});
    chk("out1", {24'h0, out1}, {24'h0, e_out[1]});
    chk("out2", {24'h0, out2}, {24'h0, e_out[2]});
    chk("out3", {24'h0, out3}, {24'h0, e_out[3]});
    chk("valid_out", {31'h0, valid_out}, {31'h0, e_valid});
    chk("err", {31'h0, err}, {31'h0, e_err});
    chk("active", {31'h0, active}, {31'h0, e_active});
    if (valid_out === 1'b1) vcnt++;
    if (err === 1'b1) ecnt++;
  end

  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic do_reset;
    reset   = 1'b1;
    data_in = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic lock4;
    repeat (4) send_byte(8'hBC);
  endtask

  task automatic chk_outs(input string name, input logic [31:0] exp);
    chk(name, {out0, out1, out2, out3}, exp);
  endtask

  initial begin
    int         v0, e0;
    logic [7:0] com_b;
    logic [2:0] rb;
    com_b   = 8'hBC;
    reset   = 1'b1;
    data_in = 1'b0;

    // reset state
    do_reset;
    chk_outs("rst_outs", 32'h0);
    chk("rst_valid", {31'h0, valid_out}, 32'h0);
    chk("rst_active", {31'h0, active}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);

    // lock: active rises exactly after the 32nd bit
    v0 = vcnt; e0 = ecnt;
    repeat (3) send_byte(8'hBC);
    for (int i = 7; i >= 1; i--) send_bit(com_b[i]);
    chk("lock_pre_active", {31'h0, active}, 32'h0);
    send_bit(com_b[0]);
    chk("lock_active", {31'h0, active}, 32'h1);
    send_byte(8'h7C);
    chk("lock_no_valid", vcnt - v0, 32'h0);
    chk("lock_no_err", ecnt - e0, 32'h0);

    // data group
    v0 = vcnt;
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    chk("grp_valid", {31'h0, valid_out}, 32'h1);
    chk_outs("grp_outs", 32'h11223344);
    send_byte(8'h7C);
    chk("grp_valid_drop", {31'h0, valid_out}, 32'h0);
    chk_outs("grp_hold", 32'h11223344);
    chk("grp_one_pulse", vcnt - v0, 32'h1);

    // idle skipping with misaligned lock
    do_reset;
    rb = 3'($urandom_range(0, 7));
    for (int i = 2; i >= 0; i--) send_bit(rb[i]);
    lock4;
    chk("mis_active", {31'h0, active}, 32'h1);
    v0 = vcnt;
    send_byte(8'h11); send_byte(8'h7C); send_byte(8'h22);
    send_byte(8'h33); send_byte(8'h7C); send_byte(8'h44);
    chk_outs("idle_outs", 32'h11223344);
    send_byte(8'h7C);
    chk("idle_one_pulse", vcnt - v0, 32'h1);

    // partial group discarded by COM
    v0 = vcnt; e0 = ecnt;
    send_byte(8'h11); send_byte(8'h22); send_byte(8'hBC);
    chk("part_err", {31'h0, err}, 32'h1);
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
    chk_outs("part_outs", 32'h55667788);
    send_byte(8'h7C);
    chk("part_err_cnt", ecnt - e0, 32'h1);
    chk("part_valid_cnt", vcnt - v0, 32'h1);

    // alignment failure then relock
    do_reset;
    e0 = ecnt;
    send_byte(8'hBC); send_byte(8'hBC); send_byte(8'h00); send_byte(8'hBC);
    chk("afail_active", {31'h0, active}, 32'h0);
    send_byte(8'hBC); send_byte(8'hBC);
    chk("afail_still_low", {31'h0, active}, 32'h0);
    send_byte(8'hBC); send_byte(8'hBC);
    chk("afail_relock", {31'h0, active}, 32'h1);
    send_byte(8'h7C);
    chk("afail_no_err", ecnt - e0, 32'h0);

    // reset mid-group
    do_reset;
    lock4;
    e0 = ecnt;
    send_byte(8'h11); send_byte(8'h22);
    do_reset;
    chk_outs("mid_rst_outs", 32'h0);
    chk("mid_rst_active", {31'h0, active}, 32'h0);
    lock4;
    send_byte(8'h99); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    chk_outs("mid_rst_grp", 32'h99AABBCC);
    send_byte(8'h7C);
    chk("mid_rst_no_err", ecnt - e0, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
